// File: rtl/m_hwuart_if.sv
// Bus-side signal bundle for the UART: single-register-select Wishbone-style
// slave with zero wait states. The master modport drives strobe/address/data.
interface m_hwuart_if;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [7:0]  DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/m_hwuart.sv
// Minimal UART with a single TX holding register and a small RX FIFO.
// Register 0 = DATA (write: transmit, read: pop RX head), 1 = STATUS.
//
// TX / RX FSM states:
//   state   | meaning
//   S_IDLE  | line idle; TX waits for thr, RX waits for a falling edge
//   S_START | start bit time (RX samples it at DIVISOR/2)
//   S_DATA  | DATABITS data bits, LSB first
//   S_STOP  | stop bit; RX may linger here after a framing error
module m_hwuart #(
  parameter int DIVISOR  = 104,
  parameter int DATABITS = 8,
  parameter int RXDEPTH  = 4
) (
  input  logic      CLK_I,
  input  logic      RST_I,
  m_hwuart_if.slave bus,
  input  logic      usartRX,
  output logic      usartTX,
  output logic      irq_rx
);
  localparam int AW = $clog2(RXDEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0]   HALF_LAST = 16'(DIVISOR / 2 - 1);
  localparam logic [3:0]    BITS_LAST = 4'(DATABITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(RXDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic rd_data, rd_stat, wr_data;
  assign bus.ACK_O = bus.STB_I;
  assign rd_data   = bus.STB_I & ~bus.WE_I & ~bus.ADR_I;
  assign rd_stat   = bus.STB_I & ~bus.WE_I &  bus.ADR_I;
  assign wr_data   = bus.STB_I &  bus.WE_I & ~bus.ADR_I;

  // ---------------- transmitter ----------------
  state_t              tx_state, tx_state_nx;
  logic [15:0]         tx_cnt, tx_cnt_nx;
  logic [3:0]          tx_bit, tx_bit_nx;
  logic [DATABITS-1:0] tx_shift, tx_shift_nx, thr_data;
  logic                tx_line_nx, thr_full, thr_take, wr_accept, txovr_set;

  // thr may refill in the very cycle it drains into the shifter
  assign wr_accept = wr_data & (~thr_full | thr_take);
  assign txovr_set = wr_data & thr_full & ~thr_take;

  // TX next-state: each state is timed by a down-counter reaching zero
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_line_nx  = usartTX;
    thr_take    = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_line_nx = 1'b1;
        if (thr_full) begin
          thr_take    = 1'b1;
          tx_shift_nx = thr_data;
          tx_cnt_nx   = BIT_LAST;
          tx_line_nx  = 1'b0;
          tx_state_nx = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx   = BIT_LAST;
          tx_bit_nx   = '0;
          tx_line_nx  = tx_shift[0];
          tx_state_nx = S_DATA;
        end else begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx = BIT_LAST;
          if (tx_bit == BITS_LAST) begin
            tx_line_nx  = 1'b1;
            tx_state_nx = S_STOP;
          end else begin
            tx_shift_nx = {1'b1, tx_shift[DATABITS-1:1]};
            tx_line_nx  = tx_shift[1];
            tx_bit_nx   = tx_bit + 4'd1;
          end
        end else begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt == '0) begin
          if (thr_full) begin
            // back-to-back frame, no idle bit in between
            thr_take    = 1'b1;
            tx_shift_nx = thr_data;
            tx_cnt_nx   = BIT_LAST;
            tx_line_nx  = 1'b0;
            tx_state_nx = S_START;
          end else begin
            tx_line_nx  = 1'b1;
            tx_state_nx = S_IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end
      end
      default: begin
        tx_line_nx  = 1'b1;
        tx_state_nx = S_IDLE;
      end
    endcase
  end

  // TX state register; usartTX is registered alongside the state
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      usartTX  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      usartTX  <= tx_line_nx;
    end
  end

  // TX holding register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      thr_full <= 1'b0;
      thr_data <= '0;
    end else begin
      if (thr_take)  thr_full <= 1'b0;
      if (wr_accept) begin
        thr_full <= 1'b1;
        thr_data <= bus.DAT_I[DATABITS-1:0];
      end
    end
  end

  // ---------------- receiver ----------------
  logic                rx_sync1, rx_s, rx_prev;
  state_t              rx_state, rx_state_nx;
  logic [15:0]         rx_cnt, rx_cnt_nx;
  logic [3:0]          rx_bit, rx_bit_nx;
  logic [DATABITS-1:0] rx_shift, rx_shift_nx;
  logic                rx_hold, rx_hold_nx, rx_push, ferr_set;

  // 2-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= usartRX;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
    end
  end

  // RX next-state: sample mid-bit; rx_hold parks in STOP after a framing error
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_hold_nx  = rx_hold;
    rx_push     = 1'b0;
    ferr_set    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev & ~rx_s) begin
          rx_cnt_nx   = HALF_LAST;
          rx_state_nx = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == '0) begin
          if (rx_s) begin
            rx_state_nx = S_IDLE;
          end else begin
            rx_cnt_nx   = BIT_LAST;
            rx_bit_nx   = '0;
            rx_state_nx = S_DATA;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_nx = {rx_s, rx_shift[DATABITS-1:1]};
          rx_cnt_nx   = BIT_LAST;
          rx_bit_nx   = rx_bit + 4'd1;
          if (rx_bit == BITS_LAST) rx_state_nx = S_STOP;
        end else begin
          rx_cnt_nx = rx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_hold) begin
          if (rx_s) begin
            rx_hold_nx  = 1'b0;
            rx_state_nx = S_IDLE;
          end
        end else if (rx_cnt == '0) begin
          if (rx_s) begin
            rx_push     = 1'b1;
            rx_state_nx = S_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_hold_nx = 1'b1;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 16'd1;
        end
      end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_hold  <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
      rx_hold  <= rx_hold_nx;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATABITS-1:0] mem [RXDEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [CW-1:0]       count;
  logic                fifo_empty, fifo_full, pop, push, rovr_set;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign pop        = rd_data & ~fifo_empty;
  assign push       = rx_push & (~fifo_full | pop);
  assign rovr_set   = rx_push & fifo_full & ~pop;
  assign irq_rx     = ~fifo_empty;

  // FIFO storage, no reset needed
  always_ff @(posedge CLK_I) begin
    if (push) mem[wptr] <= rx_shift_nx;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push & ~pop)      count <= count + CW'(1);
      else if (pop & ~push) count <= count - CW'(1);
    end
  end

  // ---------------- status and read mux ----------------
  logic ferr, rovr, txovr;

  // sticky flags: a STATUS read clears, a same-cycle event wins
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ferr  <= 1'b0;
      rovr  <= 1'b0;
      txovr <= 1'b0;
    end else begin
      ferr  <= ferr_set  | (ferr  & ~rd_stat);
      rovr  <= rovr_set  | (rovr  & ~rd_stat);
      txovr <= txovr_set | (txovr & ~rd_stat);
    end
  end

  // read data is combinational so the bus sees zero wait states
  always_comb begin
    logic [31:0] status_word;
    logic [31:0] data_word;
    status_word          = '0;
    status_word[0]       = ~fifo_empty;
    status_word[1]       = thr_full;
    status_word[2]       = (tx_state != S_IDLE);
    status_word[3]       = ferr;
    status_word[4]       = rovr;
    status_word[5]       = txovr;
    status_word[8 +: CW] = count;
    data_word = '0;
    if (!fifo_empty) begin
      data_word[DATABITS-1:0] = mem[rptr];
      data_word[8]            = 1'b1;
    end
    bus.DAT_O = '0;
    if (rd_data)      bus.DAT_O = data_word;
    else if (rd_stat) bus.DAT_O = status_word;
  end
endmodule

// File: doc/m_hwuart.md
M_HWUART -- requirements
Module: m_hwuart

Interface
REQ-001 Parameter DIVISOR, default 104: CLK_I cycles per serial bit, legal range 4..65535.
REQ-002 Parameter DATABITS, default 8: serial data bits per frame, legal range 5..8.
REQ-003 Parameter RXDEPTH, default 4: RX FIFO entries, a power of two in the range 2..16.
REQ-004 Ports SHALL be as follows, clock and reset first; one clock, reset asynchronous and active-high.
REQ-005 CLK_I  in  1  system clock.
REQ-006 RST_I  in  1  asynchronous active-high reset.
REQ-007 STB_I  in  1  Wishbone strobe, block already selected by address decode.
REQ-008 WE_I  in  1  write enable.
REQ-009 ADR_I  in  1  register select: 0 = DATA, 1 = STATUS.
REQ-010 DAT_I  in  8  write data; bits above DATABITS-1 are ignored.
REQ-011 DAT_O  out  32  read data.
REQ-012 ACK_O  out  1  acknowledge.
REQ-013 usartRX  in  1  asynchronous serial input, idle high.
REQ-014 usartTX  out  1  serial output, registered, idle high.
REQ-015 irq_rx  out  1  level, high while RX FIFO is non-empty.

Function
REQ-016 ACK_O SHALL equal STB_I combinationally, with zero wait states; each side effect SHALL occur at the clock edge where STB_I=1.
REQ-017 Frame format SHALL be 1 start bit (0), DATABITS data bits LSB first, 1 stop bit (1), no parity.
REQ-018 A write to DATA SHALL load the TX holding register (thr) when thr is empty; if thr is full, the write SHALL be discarded and sticky TXOVR set.
REQ-019 TX FSM states IDLE, START, DATA, STOP; each state SHALL last exactly DIVISOR cycles, with the bit counter running 0..DATABITS-1 in DATA.
REQ-020 In IDLE with thr full, the FSM SHALL move thr into the shifter at the next edge and enter START, clearing thr; usartTX SHALL drive 0 from the edge following the move.
REQ-021 At the end of STOP, with thr full the FSM SHALL go directly to START with no idle bit; otherwise it SHALL go to IDLE.
REQ-022 A DATA write in the same cycle that thr empties into the shifter SHALL be accepted, and TXOVR SHALL NOT be set.
REQ-023 usartRX SHALL pass through a 2-flop synchroniser; the RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-024 RX IDLE->START SHALL occur on a synchronised 1->0 transition. START SHALL sample at DIVISOR/2 (integer division) cycles; if the sample is 1, return to IDLE as a glitch with no data.
REQ-025 Data bits and the stop bit SHALL be sampled every DIVISOR cycles after the start sample.
REQ-026 A stop sample of 0 SHALL discard the byte, set sticky FERR, and return to IDLE only after the line is sampled 1.
REQ-027 A valid byte SHALL be pushed into the RX FIFO; if the FIFO is full, the byte SHALL be dropped and sticky ROVR set, with FIFO contents unchanged.
REQ-028 A read of DATA SHALL return DAT_O[DATABITS-1:0] = FIFO head, DAT_O[8] = 1, and other bits 0, and SHALL pop the head.
REQ-029 A read of DATA with the FIFO empty SHALL return 0 and SHALL NOT pop.
REQ-030 A simultaneous push and pop SHALL both take effect, leaving the count unchanged; a push into a full FIFO with a simultaneous pop SHALL succeed.
REQ-031 A read of STATUS SHALL return [0] RX non-empty, [1] thr full, [2] TX FSM not IDLE, [3] FERR, [4] ROVR, [5] TXOVR, [12:8] RX count (0..RXDEPTH), and other bits 0.
REQ-032 A read of STATUS SHALL clear FERR, ROVR and TXOVR at that edge; a set event in the same cycle SHALL win, leaving the bit 1.
REQ-033 Writes to STATUS SHALL have no effect; DAT_O SHALL be 0 whenever STB_I=0.
REQ-034 FIFO pointers SHALL be log2(RXDEPTH) bits and wrap modulo RXDEPTH; the count SHALL be log2(RXDEPTH)+1 bits.

Reset
REQ-035 While RST_I=1: usartTX=1, both FSMs IDLE, thr empty, FIFO empty (pointers and count 0), FERR=ROVR=TXOVR=0, synchroniser flops 1, irq_rx=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately; usartTX SHALL read 1 within the same cycle.
REQ-037 After release, the first TX start bit SHALL not appear before a DATA write is accepted.

Verification (DIVISOR=4, DATABITS=8, RXDEPTH=4)
REQ-038 Write 0xA5 to DATA -> usartTX is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; STATUS[2]=0 afterwards.
REQ-039 Write 0x01 then 0x02 back-to-back, then 0x03 while thr is full -> two contiguous frames, 0x03 never sent, STATUS[5]=1, and a second STATUS read returns [5]=0.
REQ-040 Drive 5 valid frames 0x11..0x15 on usartRX with no reads -> STATUS count=4, ROVR=1; DATA reads return 0x111, 0x112, 0x113, 0x114, then 0x000.
REQ-041 Drive a frame with the stop bit held 0 -> FIFO unchanged, FERR=1, irq_rx stays 0; a following valid frame 0x5A is received correctly.
REQ-042 Drive a 1-cycle low glitch on usartRX -> no push and no error flags set.
REQ-043 Assert RST_I during a TX data bit and during RX DATA -> usartTX=1 immediately, STATUS reads 0 after release.
